// File: rtl/image_frame_pkg.sv
// Shared frame geometry and pixel-memory types for the 640x480 1bpp frame store.
package image_frame_pkg;
  localparam int IMG_WIDTH     = 640;
  localparam int IMG_HEIGHT    = 480;
  localparam int BYTES_PER_ROW = 80;
  localparam int FRAME_DEPTH   = 38400;
  localparam int PIX_ADDR_W    = 16;
  localparam int PIX_DATA_W    = 8;

  typedef logic [PIX_ADDR_W-1:0] pix_addr_t;
  typedef logic [PIX_DATA_W-1:0] pix_byte_t;
endpackage

// File: rtl/image_ram_core.sv
// Bare simple-dual-port array: one write port, one registered read port, no reset.
// The read port samples the array on the edge, so a same-edge write is seen as old data.
module image_ram_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 38400
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/image_frame_ram.sv
// Frame RAM top: bounds checks, reset gating of q, optional write-first forwarding.
// Optional macro: IMAGE_FRAME_RAM_WR_FORWARD_EN (same-address read-during-write returns new data).
module image_frame_ram
  import image_frame_pkg::*;
#(
  parameter int DATA_W = PIX_DATA_W,
  parameter int ADDR_W = PIX_ADDR_W,
  parameter int DEPTH  = FRAME_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic              wren,
  input  logic [ADDR_W-1:0] rdaddress,
  output logic [DATA_W-1:0] q
);
  logic              w_wr_in_rng;
  logic              w_rd_in_rng;
  logic              w_wr_ok;
  logic [ADDR_W-1:0] w_core_rd_addr;
  logic [DATA_W-1:0] w_core_q;
  logic              w_rd_oob;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_clr;

  assign w_wr_in_rng    = 32'(wraddress) < DEPTH;
  assign w_rd_in_rng    = 32'(rdaddress) < DEPTH;
  assign w_wr_ok        = wren && !reset && w_wr_in_rng;
  // Keep the array index legal; out-of-range reads are masked at the output anyway.
  assign w_core_rd_addr = w_rd_in_rng ? rdaddress : '0;

  image_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .i_clk     (clock),
    .i_we      (w_wr_ok),
    .i_wr_addr (wraddress),
    .i_wr_data (data),
    .i_rd_addr (w_core_rd_addr),
    .o_rd_data (w_core_q)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_addr <= '0;
      r_clr     <= 1'b1;
    end else begin
      r_rd_addr <= rdaddress;
      r_clr     <= 1'b0;
    end
  end

  assign w_rd_oob = 32'(r_rd_addr) >= DEPTH;

`ifdef IMAGE_FRAME_RAM_WR_FORWARD_EN
  logic              r_fwd_hit;
  logic [DATA_W-1:0] r_fwd_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fwd_hit  <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_fwd_hit  <= w_wr_ok && (wraddress == rdaddress);
      r_fwd_data <= data;
    end
  end

  always_comb begin
    q = w_core_q;
    if (r_fwd_hit)            q = r_fwd_data;
    if (r_clr || w_rd_oob)    q = '0;
  end
`else
  always_comb begin
    q = w_core_q;
    if (r_clr || w_rd_oob) q = '0;
  end
`endif
endmodule

// File: tb/tb_image_frame_ram.sv
// Directed self-checking bench for image_frame_ram (honours IMAGE_FRAME_RAM_WR_FORWARD_EN).
module tb_image_frame_ram;
  import image_frame_pkg::*;

  logic      clock = 1'b0;
  logic      reset;
  pix_byte_t data;
  pix_addr_t wraddress;
  logic      wren;
  pix_addr_t rdaddress;
  pix_byte_t q;

  int n_checks = 0;
  int n_fail   = 0;

  image_frame_ram dut (
    .clock     (clock),
    .reset     (reset),
    .data      (data),
    .wraddress (wraddress),
    .wren      (wren),
    .rdaddress (rdaddress),
    .q         (q)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input pix_addr_t a, input pix_byte_t d);
    wren = 1'b1; wraddress = a; data = d;
    tick();
    wren = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wren = 1'b0; data = '0; wraddress = '0; rdaddress = '0;
    tick(); tick();
    n_checks++;
    if (q !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_q: got %h want 00", q);
    end
    reset = 1'b0;
  endtask

  task automatic test_sparse();
    pix_addr_t addrs [8] = '{16'd0, 16'd1, 16'd80, 16'd81, 16'd160, 16'd161, 16'd240, 16'd241};
    pix_byte_t vals  [8] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
    for (int i = 0; i < 8; i++) wr(addrs[i], vals[i]);
    for (int i = 0; i < 8; i++) begin
      rdaddress = addrs[i];
      tick();
      n_checks++;
      if (q !== vals[i]) begin
        n_fail++;
        $display("FAIL sparse_rd[%0d]: got %h want %h", addrs[i], q, vals[i]);
      end
    end
  endtask

  function automatic bit lit(input int x, input int y);
    return (x == 8 && y == 0) || (x == 1 && y == 1) || (x == 10 && y == 1) ||
           (x == 3 && y == 2) || (x == 12 && y == 2) || (x == 5 && y == 3) ||
           (x == 14 && y == 3);
  endfunction

  task automatic test_pixel_packing();
    bit exp_b;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 16; x++) begin
        rdaddress = pix_addr_t'(y * BYTES_PER_ROW + x / 8);
        tick();
        exp_b = lit(x, y);
        n_checks++;
        if (q[x % 8] !== exp_b) begin
          n_fail++;
          $display("FAIL pixel(%0d,%0d): got %b want %b", x, y, q[x % 8], exp_b);
        end
      end
    end
  endtask

  task automatic test_read_during_write();
    pix_byte_t exp_first;
`ifdef IMAGE_FRAME_RAM_WR_FORWARD_EN
    exp_first = 8'hA5;
`else
    exp_first = 8'h3C;
`endif
    wr(16'd100, 8'h3C);
    rdaddress = 16'd100;
    wren = 1'b1; wraddress = 16'd100; data = 8'hA5;
    tick();
    wren = 1'b0;
    n_checks++;
    if (q !== exp_first) begin
      n_fail++;
      $display("FAIL rdw_first: got %h want %h", q, exp_first);
    end
    tick();
    n_checks++;
    if (q !== 8'hA5) begin
      n_fail++;
      $display("FAIL rdw_reread: got %h want a5", q);
    end
  endtask

  task automatic test_bounds();
    wr(16'd38400, 8'hFF);
    wr(16'd65535, 8'hFF);
    wr(16'd38399, 8'h5A);
    rdaddress = 16'd38400;
    tick();
    n_checks++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL oob_38400: got %h want 00", q); end
    rdaddress = 16'd65535;
    tick();
    n_checks++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL oob_65535: got %h want 00", q); end
    rdaddress = 16'd38399;
    tick();
    n_checks++;
    if (q !== 8'h5A) begin n_fail++; $display("FAIL last_word: got %h want 5a", q); end
    // Dropped writes must not have aliased onto low addresses.
    rdaddress = 16'd0;
    tick();
    n_checks++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL no_alias_0: got %h want 00", q); end
  endtask

  task automatic test_reset_mid();
    wr(16'd5, 8'h77);
    rdaddress = 16'd5;
    tick();
    n_checks++;
    if (q !== 8'h77) begin n_fail++; $display("FAIL pre_reset_rd: got %h want 77", q); end
    reset = 1'b1; wren = 1'b1; data = 8'h11; wraddress = 16'd5;
    tick();
    reset = 1'b0; wren = 1'b0;
    n_checks++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL mid_reset_q: got %h want 00", q); end
    tick();
    n_checks++;
    if (q !== 8'h77) begin n_fail++; $display("FAIL post_reset_rd: got %h want 77", q); end
  endtask

  task automatic test_back_to_back();
    pix_byte_t exp_lo [8] = '{8'h00, 8'h01, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87};
    for (int i = 2; i < 8; i++) wr(pix_addr_t'(i), exp_lo[i]);
    for (int i = 0; i < 8; i++) begin
      rdaddress = pix_addr_t'(i);
      wren = 1'b1; wraddress = pix_addr_t'(200 + i); data = pix_byte_t'(8'hC0 + i);
      tick();
      n_checks++;
      if (q !== exp_lo[i]) begin
        n_fail++;
        $display("FAIL stream_rd[%0d]: got %h want %h", i, q, exp_lo[i]);
      end
    end
    wren = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rdaddress = pix_addr_t'(200 + i);
      tick();
      n_checks++;
      if (q !== pix_byte_t'(8'hC0 + i)) begin
        n_fail++;
        $display("FAIL stream_wr[%0d]: got %h want %h", 200 + i, q, 8'hC0 + i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sparse();
    test_pixel_packing();
    test_read_during_write();
    test_bounds();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
